axi_rd_arbiter: RTL
===================

# axi_rd_arbiter

Two-requester AXI4 read-channel arbiter that shares the core's single `io_master` AR/R port between the instruction-fetch unit (IFU) and the load/store unit (LSU). It sits inside `ysyx_040053`, between the two cache refill engines and the top-level `io_master_ar*`/`io_master_r*` pins. It allows one outstanding read burst at a time, grants round-robin, and routes R beats back to the granted requester. The write channels do not pass through this block.

## Interface
Parameters:
- `ADDR_W`, default 32: AR address width.
- `DATA_W`, default 64: R data width.
- `ID_W`, default 4: AXI ID width.
- `IFU_ID`, default 4'd0: ARID driven for IFU bursts.
- `LSU_ID`, default 4'd1: ARID driven for LSU bursts.

Ports:
- `clock` in 1: single clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `ifu_arvalid`, `lsu_arvalid` in 1: read request valid.
- `ifu_arready`, `lsu_arready` out 1: AR accepted.
- `ifu_araddr`, `lsu_araddr` in ADDR_W: burst address.
- `ifu_arlen`, `lsu_arlen` in 8: beats minus 1.
- `ifu_arsize`, `lsu_arsize` in 3: beat size.
- `ifu_arburst`, `lsu_arburst` in 2: burst type.
- `ifu_rvalid`, `lsu_rvalid` out 1: beat valid to requester.
- `ifu_rready`, `lsu_rready` in 1: requester accepts beat.
- `ifu_rdata`, `lsu_rdata` out DATA_W: beat data. Broadcast to both requesters.
- `ifu_rresp`, `lsu_rresp` out 2: beat response.
- `ifu_rlast`, `lsu_rlast` out 1: last beat.
- `io_master_arvalid` out 1, `io_master_arready` in 1, `io_master_araddr` out ADDR_W, `io_master_arid` out ID_W, `io_master_arlen` out 8, `io_master_arsize` out 3, `io_master_arburst` out 2.
- `io_master_rvalid` in 1, `io_master_rready` out 1, `io_master_rdata` in DATA_W, `io_master_rresp` in 2, `io_master_rlast` in 1, `io_master_rid` in ID_W.
- `err_rid` out 1: sticky protocol-error flag (see Configuration).

## Operation
- State machine `IDLE` → `AR` → `R` → `IDLE`.
- Registers: `state`, `grant` (0 = IFU, 1 = LSU), `last_grant`, `arlen_q` (8 bits), `beat_cnt` (8 bits), `err_rid`.
- **IDLE**
  - If either `*_arvalid` is high, latch `grant` and go to `AR`.
  - If only one requester is valid, grant it.
  - If both are valid, grant the requester that is not `last_grant`.
  - `last_grant` resets to IFU, so the LSU wins the first tie.
- **AR**
  - `io_master_ar*` are a combinational mux of the granted requester's fields. `io_master_arid` is `IFU_ID` or `LSU_ID` accordingly.
  - `io_master_arvalid` equals the granted requester's `arvalid`.
  - The granted `*_arready` equals `io_master_arready`. The other requester's `arready` is 0.
  - On AR handshake: latch `arlen_q`, clear `beat_cnt`, set `last_grant <= grant`, go to `R`.
- **R**
  - The granted `*_rvalid` equals `io_master_rvalid`. `io_master_rready` equals the granted `*_rready`.
  - The non-granted requester sees `rvalid` = 0.
  - `rdata`, `rresp` and `rlast` are forwarded unchanged.
  - Each beat handshake increments `beat_cnt`.
  - On a handshake with `io_master_rlast`=1, go to `IDLE`.
- Requesters must hold `arvalid` and fields stable until `arready`, per AXI. If the granted requester drops `arvalid` in `AR`, the block waits; it never re-arbitrates mid-`AR`.
- Reset values:
  - `state`=IDLE, `grant`=0, `last_grant`=IFU, `beat_cnt`=0, `err_rid`=0.
  - All `*_arready`, `*_rvalid`, `io_master_arvalid` and `io_master_rready` are 0.
- Reset asserted mid-burst:
  - The FSM returns to IDLE at once and outputs go to their reset values asynchronously.
  - Any in-flight beats from the slave are not forwarded after reset.

## Timing
- Request-to-AR latency:
  - `arvalid` high in cycle n (state IDLE) gives `io_master_arvalid` high in cycle n+1.
  - With `arready` high, the handshake completes in cycle n+1.
- R path is combinational, with 0-cycle forwarding in both directions (valid/ready).
- Turnaround: the `rlast` handshake in cycle m puts the block in IDLE in cycle m+1. The next AR is then earliest in cycle m+2.
- No AR is issued while in `R`.
- `io_master_rvalid` arriving in `IDLE` or `AR` is not acknowledged (`io_master_rready`=0).

## Configuration
- Macro: `AXI_RD_ARB_ID_CHECK_EN`.
- Defined:
  - On each R handshake, `err_rid` sets (sticky until reset) if either condition holds:
    - `io_master_rid` ≠ the granted ID.
    - `io_master_rlast` disagrees with (`beat_cnt` == `arlen_q`).
  - A beat that sets `err_rid` is forwarded with `rresp` forced to 2'b10 (SLVERR).
- Undefined:
  - `err_rid` is tied 0.
  - `beat_cnt` and `arlen_q` are removed.
  - `rresp` passes unchanged.

## Test plan
- **Single IFU burst:** `ifu_araddr`=0x8000_0000, arlen=3. Expect `io_master_arid`=0 and `io_master_arvalid` one cycle after request. After 4 beats, `ifu_rlast`=1 on beat 4, `lsu_rvalid` is never high, and the FSM is back in IDLE the following cycle.
- **Simultaneous requests after reset:** both valid in cycle n. LSU is granted first (`arid`=1). After its `rlast`, IFU is granted (`arid`=0); the IFU AR is seen 2 cycles after the LSU `rlast`.
- **Back-pressure:** hold `io_master_arready`=0 for 5 cycles. `ifu_arready` stays 0 and the AR fields stay stable. Then toggle `ifu_rready` 1/0 per cycle over an 8-beat burst. All 8 beats are delivered in order, with no beat lost or duplicated.
- **Reset mid-burst:** assert `reset` after beat 2 of a 4-beat LSU burst. `lsu_rvalid` and `io_master_rready` go to 0 immediately. After release, a new IFU request is granted normally.
- **ID check (macro defined):**
  - Return `io_master_rid`=1 during an IFU burst: `err_rid`=1 and `ifu_rresp`=2'b10 on that beat.
  - Assert `rlast` on beat 2 of an arlen=3 burst: `err_rid`=1.
  - With the macro undefined, the same stimulus leaves `err_rid`=0 and `rresp` unchanged.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 read port (AR/R) between the instruction
// fetch unit (IFU) and the load/store unit (LSU). It allows one burst in
// flight at a time, picks round-robin on a tie, and steers R beats back to
// the owner of the current burst.
//
// Ports:
//   clock, reset            - clock; asynchronous active-high reset
//   ifu_ar* / lsu_ar*       - per-requester AR channel (valid/ready + fields)
//   ifu_r*  / lsu_r*        - per-requester R channel; rdata/rresp/rlast broadcast
//   io_master_ar*           - shared AR channel toward the slave
//   io_master_r*            - shared R channel from the slave
//   err_rid                 - sticky RID/RLAST protocol-error flag
//
// Optional feature: define AXI_RD_ARB_ID_CHECK_EN to check RID and RLAST on
// every beat. A bad beat is returned with SLVERR and sets err_rid. Without
// the macro, err_rid is tied low and rresp passes through untouched.
module axi_rd_arbiter #(
    parameter int unsigned      ADDR_W = 32,
    parameter int unsigned      DATA_W = 64,
    parameter int unsigned      ID_W   = 4,
    parameter logic [ID_W-1:0]  IFU_ID = ID_W'(0),
    parameter logic [ID_W-1:0]  LSU_ID = ID_W'(1)
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic [7:0]        ifu_arlen,
    input  logic [2:0]        ifu_arsize,
    input  logic [1:0]        ifu_arburst,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,
    output logic              ifu_rlast,

    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic [7:0]        lsu_arlen,
    input  logic [2:0]        lsu_arsize,
    input  logic [1:0]        lsu_arburst,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,
    output logic              lsu_rlast,

    output logic              io_master_arvalid,
    input  logic              io_master_arready,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic [ID_W-1:0]   io_master_arid,
    output logic [7:0]        io_master_arlen,
    output logic [2:0]        io_master_arsize,
    output logic [1:0]        io_master_arburst,

    input  logic              io_master_rvalid,
    output logic              io_master_rready,
    input  logic [DATA_W-1:0] io_master_rdata,
    input  logic [1:0]        io_master_rresp,
    input  logic              io_master_rlast,
    input  logic [ID_W-1:0]   io_master_rid,

    output logic              err_rid
);

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // grant: 0 = IFU, 1 = LSU
    logic grant;
    logic grant_nx;
    logic last_grant;

    logic            sel_arvalid;
    logic            sel_rready;
    logic [7:0]      sel_arlen;
    logic [ID_W-1:0] grant_id;
    logic            ar_hs;
    logic            r_hs;
    logic            beat_bad;
    logic [1:0]      rresp_fwd;

    // Granted requester's view of the handshake inputs
    assign sel_arvalid = grant ? lsu_arvalid : ifu_arvalid;
    assign sel_rready  = grant ? lsu_rready  : ifu_rready;
    assign sel_arlen   = grant ? lsu_arlen   : ifu_arlen;
    assign grant_id    = grant ? LSU_ID      : IFU_ID;

    assign ar_hs = (state == AR) && sel_arvalid && io_master_arready;
    assign r_hs  = (state == R)  && io_master_rvalid && sel_rready;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and arbitration decision
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        case (state)
            IDLE: begin
                if (ifu_arvalid || lsu_arvalid) begin
                    state_nx = AR;
                    // On a tie the requester served last time yields
                    if (ifu_arvalid && lsu_arvalid) begin
                        grant_nx = ~last_grant;
                    end else begin
                        grant_nx = lsu_arvalid;
                    end
                end
            end
            AR: begin
                if (ar_hs) begin
                    state_nx = R;
                end
            end
            R: begin
                if (r_hs && io_master_rlast) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Grant bookkeeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant      <= 1'b0;
            last_grant <= 1'b0;
        end else begin
            grant <= grant_nx;
            if (ar_hs) begin
                last_grant <= grant;
            end
        end
    end

`ifdef AXI_RD_ARB_ID_CHECK_EN
    logic [7:0] arlen_q;
    logic [7:0] beat_cnt;
    logic       err_q;

    // A beat is bad if it carries a foreign ID or its RLAST disagrees with the count
    assign beat_bad = (io_master_rid != grant_id) ||
                      (io_master_rlast != (beat_cnt == arlen_q));

    // Burst length tracking and sticky error flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arlen_q  <= 8'd0;
            beat_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            if (ar_hs) begin
                arlen_q  <= sel_arlen;
                beat_cnt <= 8'd0;
            end else if (r_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (r_hs && beat_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_rid = err_q;
`else
    logic unused_rid;

    assign beat_bad   = 1'b0;
    assign err_rid    = 1'b0;
    assign unused_rid = ^{io_master_rid, sel_arlen, r_hs};
`endif

    assign rresp_fwd = beat_bad ? RESP_SLVERR : io_master_rresp;

    // Output steering; everything is gated by the current state
    always_comb begin
        io_master_arvalid = 1'b0;
        io_master_rready  = 1'b0;
        ifu_arready       = 1'b0;
        lsu_arready       = 1'b0;
        ifu_rvalid        = 1'b0;
        lsu_rvalid        = 1'b0;

        io_master_araddr  = grant ? lsu_araddr  : ifu_araddr;
        io_master_arlen   = sel_arlen;
        io_master_arsize  = grant ? lsu_arsize  : ifu_arsize;
        io_master_arburst = grant ? lsu_arburst : ifu_arburst;
        io_master_arid    = grant_id;

        ifu_rdata = io_master_rdata;
        lsu_rdata = io_master_rdata;
        ifu_rresp = rresp_fwd;
        lsu_rresp = rresp_fwd;
        ifu_rlast = io_master_rlast;
        lsu_rlast = io_master_rlast;

        case (state)
            AR: begin
                io_master_arvalid = sel_arvalid;
                if (grant) begin
                    lsu_arready = io_master_arready;
                end else begin
                    ifu_arready = io_master_arready;
                end
            end
            R: begin
                io_master_rready = sel_rready;
                if (grant) begin
                    lsu_rvalid = io_master_rvalid;
                end else begin
                    ifu_rvalid = io_master_rvalid;
                end
            end
            default: ;
        endcase
    end

endmodule
